// File: rtl/draw_pkg.sv
// Shared screen geometry, colours and FSM state encoding for the VGA drawing path.
package draw_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int X_MAX    = 159;
    localparam int Y_MAX    = 119;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DRAW = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/rect_raster.sv
// Column/row walker for a filled rectangle with last-pixel detect and screen clip.
module rect_raster import draw_pkg::*; #(
    parameter int X_W   = draw_pkg::X_W,
    parameter int Y_W   = draw_pkg::Y_W,
    parameter int X_MAX = draw_pkg::X_MAX,
    parameter int Y_MAX = draw_pkg::Y_MAX
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [X_W-1:0] w,
    input  logic [Y_W-1:0] h,
    input  logic           step,
    output logic [X_W-1:0] cur_x,
    output logic [Y_W-1:0] cur_y,
    output logic           visible,
    output logic           last
);

    localparam logic [X_W:0] X_ONE = (X_W+1)'(1);
    localparam logic [Y_W:0] Y_ONE = (Y_W+1)'(1);
    localparam logic [X_W:0] X_LIM = (X_W+1)'(X_MAX);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(Y_MAX);

    logic [X_W:0] cx_q, cx_d, x0_q, ex_q, xs, ex, cx_full;
    logic [Y_W:0] cy_q, cy_d, ey_q, ey, cy_full;
    logic         row_end;

    // On load the command fields bypass the registers so pixel 0 is available in the accept cycle.
    always_comb begin
        xs      = load ? {1'b0, x0} : x0_q;
        ex      = load ? ({1'b0, x0} + {1'b0, w}) : ex_q;
        ey      = load ? ({1'b0, y0} + {1'b0, h}) : ey_q;
        cx_full = load ? {1'b0, x0} : cx_q;
        cy_full = load ? {1'b0, y0} : cy_q;
        row_end = (cx_full + X_ONE) == ex;
        last    = row_end && ((cy_full + Y_ONE) == ey);
        visible = (cx_full <= X_LIM) && (cy_full <= Y_LIM);
        cx_d    = row_end ? xs : (cx_full + X_ONE);
        cy_d    = row_end ? (cy_full + Y_ONE) : cy_full;
        cur_x   = cx_full[X_W-1:0];
        cur_y   = cy_full[Y_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cx_q <= '0;
            cy_q <= '0;
            x0_q <= '0;
            ex_q <= '0;
            ey_q <= '0;
        end else if (load || step) begin
            cx_q <= cx_d;
            cy_q <= cy_d;
            x0_q <= xs;
            ex_q <= ex;
            ey_q <= ey;
        end
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Round-robin sharing of the vga_adapter pixel port between two filled-rectangle requesters.
module vga_draw_arbiter import draw_pkg::*; #(
    parameter int X_W   = draw_pkg::X_W,
    parameter int Y_W   = draw_pkg::Y_W,
    parameter int X_MAX = draw_pkg::X_MAX,
    parameter int Y_MAX = draw_pkg::Y_MAX
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [X_W-1:0]      req0_x,
    input  logic [Y_W-1:0]      req0_y,
    input  logic [X_W-1:0]      req0_w,
    input  logic [Y_W-1:0]      req0_h,
    input  logic [COLOUR_W-1:0] req0_colour,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [X_W-1:0]      req1_x,
    input  logic [Y_W-1:0]      req1_y,
    input  logic [X_W-1:0]      req1_w,
    input  logic [Y_W-1:0]      req1_h,
    input  logic [COLOUR_W-1:0] req1_colour,
    output logic                done0,
    output logic                done1,
    output logic                plot,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                busy
);

    logic [1:0]          state_q, state_d;
    logic                last_q, last_d;
    logic                owner_q, owner_d;
    logic                pix_last_q, pix_last_d;
    logic [COLOUR_W-1:0] fill_q, fill_d;
    logic                plot_q, plot_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                busy_q;

    logic                choice, accept, empty, load, step;
    logic [X_W-1:0]      sel_x, sel_w, r_x;
    logic [Y_W-1:0]      sel_y, sel_h, r_y;
    logic [COLOUR_W-1:0] sel_c;
    logic                r_visible, r_last;

    always_comb begin
        choice = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        accept = (state_q == ST_IDLE) && (req0_valid || req1_valid);
        sel_x  = choice ? req1_x      : req0_x;
        sel_y  = choice ? req1_y      : req0_y;
        sel_w  = choice ? req1_w      : req0_w;
        sel_h  = choice ? req1_h      : req0_h;
        sel_c  = choice ? req1_colour : req0_colour;
        empty  = (sel_w == '0) || (sel_h == '0);
        load   = accept && !empty;
    end

    // Readies are held low while reset is asserted so every output reads 0 during reset.
    assign req0_ready = reset && (state_q == ST_IDLE) && !choice;
    assign req1_ready = reset && (state_q == ST_IDLE) &&  choice;

    rect_raster #(
        .X_W   (X_W),
        .Y_W   (Y_W),
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_raster (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .x0      (sel_x),
        .y0      (sel_y),
        .w       (sel_w),
        .h       (sel_h),
        .step    (step),
        .cur_x   (r_x),
        .cur_y   (r_y),
        .visible (r_visible),
        .last    (r_last)
    );

    // The raster runs one pixel ahead of the output registers; pix_last_q marks the pixel on screen as final.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        fill_d     = fill_q;
        pix_last_d = pix_last_q;
        plot_d     = 1'b0;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        step       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    owner_d = choice;
                    last_d  = choice;
                    fill_d  = sel_c;
                    if (empty) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_DRAW;
                        plot_d     = r_visible;
                        pix_last_d = r_last;
                        if (r_visible) begin
                            x_d      = r_x;
                            y_d      = r_y;
                            colour_d = sel_c;
                        end
                    end
                end
            end
            ST_DRAW: begin
                if (pix_last_q) begin
                    state_d = ST_DONE;
                end else begin
                    step       = 1'b1;
                    plot_d     = r_visible;
                    pix_last_d = r_last;
                    if (r_visible) begin
                        x_d      = r_x;
                        y_d      = r_y;
                        colour_d = fill_q;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            fill_q     <= BLACK;
            pix_last_q <= 1'b0;
            plot_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= BLACK;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            fill_q     <= fill_d;
            pix_last_q <= pix_last_d;
            plot_q     <= plot_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign done0  = (state_q == ST_DONE) && !owner_q;
    assign done1  = (state_q == ST_DONE) &&  owner_q;
    assign plot   = plot_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Randomized bench for vga_draw_arbiter against a cycle-indexed reference of the drawing rules.
module tb_vga_draw_arbiter;
    import draw_pkg::*;

    typedef struct {
        int x;
        int y;
        int w;
        int h;
        int c;
    } cmd_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_x, req0_w, req1_x, req1_w;
    logic [6:0] req0_y, req0_h, req1_y, req1_h;
    logic [2:0] req0_colour, req1_colour;
    logic       done0, done1, plot, busy;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    vga_draw_arbiter #(
        .X_W   (8),
        .Y_W   (7),
        .X_MAX (159),
        .Y_MAX (119)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_x      (req0_x),
        .req0_y      (req0_y),
        .req0_w      (req0_w),
        .req0_h      (req0_h),
        .req0_colour (req0_colour),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_x      (req1_x),
        .req1_y      (req1_y),
        .req1_w      (req1_w),
        .req1_h      (req1_h),
        .req1_colour (req1_colour),
        .done0       (done0),
        .done1       (done1),
        .plot        (plot),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    cmd_t q0[$];
    cmd_t q1[$];
    int   glog[$];
    int   plog[$];
    int   dcnt0 = 0;
    int   dcnt1 = 0;

    function automatic cmd_t mk(int cx, int cy, int cw, int ch, int cc);
        cmd_t c;
        c.x = cx; c.y = cy; c.w = cw; c.h = ch; c.c = cc;
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        cmd_t c;
        c.x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(140, 255)) : int'($urandom_range(0, 159));
        c.y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 119));
        c.w = int'($urandom_range(0, 6));
        c.h = int'($urandom_range(0, 4));
        c.c = int'($urandom_range(0, 7));
        return c;
    endfunction

    // Requesters: present the queue head until it is taken; junk on the fields while idle.
    initial begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_x = '0; req0_y = '0; req0_w = '0; req0_h = '0; req0_colour = '0;
        req1_x = '0; req1_y = '0; req1_w = '0; req1_h = '0; req1_colour = '0;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                req0_valid = 1'b1;
                req0_x = 8'(q0[0].x); req0_y = 7'(q0[0].y); req0_w = 8'(q0[0].w);
                req0_h = 7'(q0[0].h); req0_colour = 3'(q0[0].c);
            end else begin
                req0_valid = 1'b0;
                req0_x = 8'($urandom); req0_y = 7'($urandom); req0_w = 8'($urandom);
                req0_h = 7'($urandom); req0_colour = 3'($urandom);
            end
            if (q1.size() > 0) begin
                req1_valid = 1'b1;
                req1_x = 8'(q1[0].x); req1_y = 7'(q1[0].y); req1_w = 8'(q1[0].w);
                req1_h = 7'(q1[0].h); req1_colour = 3'(q1[0].c);
            end else begin
                req1_valid = 1'b0;
                req1_x = 8'($urandom); req1_y = 7'($urandom); req1_w = 8'($urandom);
                req1_h = 7'($urandom); req1_colour = 3'($urandom);
            end
        end
    end

    // Reference: one command in flight, outputs derived from accept cycle and pixel index.
    bit m_act  = 1'b0;
    bit m_last = 1'b1;
    int m_a, m_x, m_y, m_w, m_h, m_c, m_own;
    int ex_x = 0, ex_y = 0, ex_c = 0;
    int n, i, col, row;
    bit idle, ch, e_plot, e_done0, e_done1, e_busy;

    function automatic bit m_idle();
        return !m_act || (cyc >= m_a + m_w * m_h + 2);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            m_act = 1'b0; m_last = 1'b1; ex_x = 0; ex_y = 0; ex_c = 0;
            check("rst_plot", plot, 0);
            check("rst_x", x, 0);
            check("rst_y", y, 0);
            check("rst_colour", colour, 0);
            check("rst_done0", done0, 0);
            check("rst_done1", done1, 0);
            check("rst_busy", busy, 0);
            check("rst_ready0", req0_ready, 0);
            check("rst_ready1", req1_ready, 0);
        end else begin
            e_plot = 0; e_done0 = 0; e_done1 = 0; e_busy = 0; idle = 1;
            if (m_act) begin
                n = m_w * m_h;
                if (cyc >= m_a + 1 && cyc <= m_a + n) begin
                    i   = cyc - m_a - 1;
                    col = m_x + i % m_w;
                    row = m_y + i / m_w;
                    if (col <= X_MAX && row <= Y_MAX) begin
                        e_plot = 1; ex_x = col; ex_y = row; ex_c = m_c;
                    end
                end
                if (cyc == m_a + 1 + n) begin
                    if (m_own == 0) e_done0 = 1; else e_done1 = 1;
                end
                e_busy = (cyc >= m_a + 1) && (cyc <= m_a + n + 1);
                idle   = (cyc >= m_a + n + 2);
            end
            ch = (req0_valid && req1_valid) ? !m_last : req1_valid;
            check("plot", plot, e_plot);
            check("x", x, ex_x);
            check("y", y, ex_y);
            check("colour", colour, ex_c);
            check("done0", done0, e_done0);
            check("done1", done1, e_done1);
            check("busy", busy, e_busy);
            check("ready0", req0_ready, idle && !ch);
            check("ready1", req1_ready, idle && ch);
            if (req0_valid && req0_ready) glog.push_back(0);
            if (req1_valid && req1_ready) glog.push_back(1);
            if (plot) plog.push_back(int'(x) * 256 + int'(y));
            if (done0) dcnt0++;
            if (done1) dcnt1++;
            if (idle && (req0_valid || req1_valid)) begin
                m_act = 1; m_a = cyc; m_own = ch ? 1 : 0; m_last = ch;
                m_x = ch ? int'(req1_x) : int'(req0_x);
                m_y = ch ? int'(req1_y) : int'(req0_y);
                m_w = ch ? int'(req1_w) : int'(req0_w);
                m_h = ch ? int'(req1_h) : int'(req0_h);
                m_c = ch ? int'(req1_colour) : int'(req0_colour);
                if (ch) begin
                    if (q1.size() > 0) void'(q1.pop_front());
                end else begin
                    if (q0.size() > 0) void'(q0.pop_front());
                end
            end
        end
    end

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (k < 5000 && !(q0.size() == 0 && q1.size() == 0 && m_idle())) begin
            @(posedge clk);
            #2;
            k++;
        end
        check({tag, "_idle"}, k < 5000, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        // Small square, fully visible
        @(posedge clk); #2;
        plog.delete();
        q0.push_back(mk(15, 20, 2, 2, 7));
        wait_idle("A");
        check("A_npix", plog.size(), 4);
        if (plog.size() == 4) begin
            check("A_p0", plog[0], 15 * 256 + 20);
            check("A_p1", plog[1], 16 * 256 + 20);
            check("A_p2", plog[2], 15 * 256 + 21);
            check("A_p3", plog[3], 16 * 256 + 21);
        end

        // Both requesters contend from reset, each with two commands queued
        @(posedge clk); #2 reset = 1'b0;
        q0.push_back(mk(10, 10, 3, 2, 1));
        q0.push_back(mk(12, 40, 2, 1, 2));
        q1.push_back(mk(60, 50, 2, 2, 4));
        q1.push_back(mk(70, 60, 1, 3, 5));
        repeat (2) @(posedge clk);
        #2;
        glog.delete(); dcnt0 = 0; dcnt1 = 0;
        reset = 1'b1;
        wait_idle("B");
        check("B_ngrants", glog.size(), 4);
        if (glog.size() == 4) begin
            check("B_g0", glog[0], 0);
            check("B_g1", glog[1], 1);
            check("B_g2", glog[2], 0);
            check("B_g3", glog[3], 1);
        end
        check("B_done0_cnt", dcnt0, 2);
        check("B_done1_cnt", dcnt1, 2);

        // Empty command on req1
        @(posedge clk); #2;
        plog.delete(); dcnt1 = 0;
        q1.push_back(mk(40, 30, 0, 5, 3));
        wait_idle("C");
        check("C_npix", plog.size(), 0);
        check("C_done1_cnt", dcnt1, 1);

        // Bottom-right corner clipping
        @(posedge clk); #2;
        plog.delete();
        q0.push_back(mk(158, 119, 4, 2, 5));
        wait_idle("D");
        check("D_npix", plog.size(), 2);
        if (plog.size() == 2) begin
            check("D_p0", plog[0], 158 * 256 + 119);
            check("D_p1", plog[1], 159 * 256 + 119);
        end

        // Random traffic
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0, 3: begin q0.push_back(rnd_cmd()); q1.push_back(rnd_cmd()); end
                1: q0.push_back(rnd_cmd());
                default: q1.push_back(rnd_cmd());
            endcase
            repeat ($urandom_range(0, 8)) @(posedge clk);
            #2;
        end
        wait_idle("R");

        // Border command interrupted by reset at pixel 60
        @(posedge clk); #2;
        q0.push_back(mk(15, 105, 130, 1, int'(WHITE)));
        k = 0;
        while (q0.size() > 0 && k < 1000) begin @(posedge clk); #2; k++; end
        while (cyc < m_a + 61 && k < 2000) begin @(posedge clk); #2; k++; end
        check("E_reach", k < 2000, 1);
        check("E_pre_plot", plot, 1);
        check("E_pre_x", x, 75);
        check("E_pre_colour", colour, int'(WHITE));
        dcnt0 = 0; glog.delete();
        reset = 1'b0;
        #1;
        check("E_async_plot", plot, 0);
        check("E_async_x", x, 0);
        check("E_async_y", y, 0);
        check("E_async_colour", colour, int'(BLACK));
        check("E_async_busy", busy, 0);
        q0.push_back(mk(5, 5, 2, 1, 6));
        q1.push_back(mk(30, 5, 1, 2, 2));
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        wait_idle("E");
        check("E_ngrants", glog.size(), 2);
        check("E_first_grant", (glog.size() > 0) ? glog[0] : 99, 0);
        check("E_done0_cnt", dcnt0, 1);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
